// File: rtl/mem_stage.sv
// Memory-access stage: single-outstanding req/ack data-memory port, load alignment/extension,
// write-back mux and stall request. Optional MEM_MISALIGN_TRAP_EN flags misaligned accesses.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_alu_result,
    input  logic        mem_wr_bck_en,
    input  logic [4:0]  mem_wr_reg_addr,
    input  logic [2:0]  mem_loadtype,
    input  logic [1:0]  mem_storetype,
    input  logic [31:0] mem_store_data,
    input  logic        mem_isload,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] wb_data,
    output logic        wb_en,
    output logic [4:0]  wb_reg_addr,
    output logic        stall_req,
    output logic        misalign_exc
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] rdata_q, rdata_d;

    logic        is_load, is_store, mem_op, misalign, issue;
    logic [1:0]  lane;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign lane     = mem_alu_result[1:0];
    assign is_load  = mem_isload && (mem_loadtype >= 3'd1) && (mem_loadtype <= 3'd5);
    assign is_store = (mem_storetype != 2'd0) && !is_load;
    assign mem_op   = is_load || is_store;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign =
        (is_load && (((mem_loadtype == 3'd2 || mem_loadtype == 3'd5) && lane[0]) ||
                     (mem_loadtype == 3'd3 && lane != 2'd0))) ||
        (is_store && ((mem_storetype == 2'd2 && lane[0]) ||
                      (mem_storetype == 2'd3 && lane != 2'd0)));
`else
    assign misalign = 1'b0;
`endif

    assign issue = mem_op && !misalign;

    // Store lane enables and replicated data; loads read the whole word.
    always_comb begin
        dmem_addr  = {mem_alu_result[31:2], 2'b00};
        dmem_we    = is_store;
        dmem_be    = 4'b1111;
        dmem_wdata = mem_store_data;
        if (is_store) begin
            case (mem_storetype)
                2'd1: begin
                    dmem_be    = 4'b0001 << lane;
                    dmem_wdata = {4{mem_store_data[7:0]}};
                end
                2'd2: begin
                    dmem_be    = lane[1] ? 4'b1100 : 4'b0011;
                    dmem_wdata = {2{mem_store_data[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = mem_store_data;
                end
            endcase
        end
    end

    always_comb begin
        unique case (lane)
            2'd0: ld_byte = rdata_q[7:0];
            2'd1: ld_byte = rdata_q[15:8];
            2'd2: ld_byte = rdata_q[23:16];
            default: ld_byte = rdata_q[31:24];
        endcase
        ld_half = lane[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (mem_loadtype)
            3'd1: ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd2: ld_data = {{16{ld_half[15]}}, ld_half};
            3'd4: ld_data = {24'd0, ld_byte};
            3'd5: ld_data = {16'd0, ld_half};
            default: ld_data = rdata_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        rdata_d      = rdata_q;
        dmem_req     = 1'b0;
        stall_req    = 1'b0;
        misalign_exc = 1'b0;
        wb_data      = mem_alu_result;
        wb_en        = mem_wr_bck_en;
        wb_reg_addr  = mem_wr_reg_addr;

        case (state_q)
            StIdle: begin
                if (issue) begin
                    dmem_req  = 1'b1;
                    stall_req = 1'b1;
                    if (dmem_ack) begin
                        rdata_d = dmem_rdata;
                        state_d = StDone;
                    end else begin
                        state_d = StWait;
                    end
                end else if (mem_op) begin
                    misalign_exc = 1'b1;
                    wb_en        = 1'b0;
                end
            end
            StWait: begin
                dmem_req  = 1'b1;
                stall_req = 1'b1;
                if (dmem_ack) begin
                    rdata_d = dmem_rdata;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (is_load) begin
                    wb_data = ld_data;
                end else if (is_store) begin
                    wb_en = 1'b0;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (stall_req) wb_en = 1'b0;

        // Reset abandons any pending request in the same cycle.
        if (rst) begin
            dmem_req     = 1'b0;
            stall_req    = 1'b0;
            wb_en        = 1'b0;
            misalign_exc = 1'b0;
            state_d      = StIdle;
            rdata_d      = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        rdata_q <= rdata_d;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; define MEM_MISALIGN_TRAP_EN to check the trap build.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [31:0] mem_alu_result;
    logic        mem_wr_bck_en;
    logic [4:0]  mem_wr_reg_addr;
    logic [2:0]  mem_loadtype;
    logic [1:0]  mem_storetype;
    logic [31:0] mem_store_data;
    logic        mem_isload;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] wb_data;
    logic        wb_en;
    logic [4:0]  wb_reg_addr;
    logic        stall_req;
    logic        misalign_exc;

    int n_cmp = 0;
    int n_bad = 0;
    int n_req;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .mem_alu_result (mem_alu_result),
        .mem_wr_bck_en  (mem_wr_bck_en),
        .mem_wr_reg_addr(mem_wr_reg_addr),
        .mem_loadtype   (mem_loadtype),
        .mem_storetype  (mem_storetype),
        .mem_store_data (mem_store_data),
        .mem_isload     (mem_isload),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
        .wb_data        (wb_data),
        .wb_en          (wb_en),
        .wb_reg_addr    (wb_reg_addr),
        .stall_req      (stall_req),
        .misalign_exc   (misalign_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge, checks happen 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [31:0] addr, input logic [2:0] lt, input logic [1:0] st,
                          input logic isld, input logic [31:0] sdata);
        mem_alu_result = addr;
        mem_loadtype   = lt;
        mem_storetype  = st;
        mem_isload     = isld;
        mem_store_data = sdata;
    endtask

    initial begin
        rst             = 1'b1;
        mem_wr_bck_en   = 1'b1;
        mem_wr_reg_addr = 5'd5;
        dmem_ack        = 1'b0;
        dmem_rdata      = 32'd0;
        set_op(32'h100, 3'd3, 2'd0, 1'b1, 32'd0);
        #1;
        // Reset overrides a pending load request.
        check_eq("rst_req",   {31'd0, dmem_req},     32'd0);
        check_eq("rst_stall", {31'd0, stall_req},    32'd0);
        check_eq("rst_wben",  {31'd0, wb_en},        32'd0);
        check_eq("rst_exc",   {31'd0, misalign_exc}, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Non-memory pass-through.
        set_op(32'h1234, 3'd0, 2'd0, 1'b0, 32'd0);
        #1;
        check_eq("add_data",  wb_data,               32'h1234);
        check_eq("add_wben",  {31'd0, wb_en},        32'd1);
        check_eq("add_rd",    {27'd0, wb_reg_addr},  32'd5);
        check_eq("add_stall", {31'd0, stall_req},    32'd0);
        check_eq("add_req",   {31'd0, dmem_req},     32'd0);
        tick();

        // lb 0x103, ack after two wait cycles.
        mem_wr_reg_addr = 5'd7;
        set_op(32'h103, 3'd1, 2'd0, 1'b1, 32'd0);
        dmem_rdata = 32'h80FF_0000;
        #1;
        check_eq("lb_addr", dmem_addr,          32'h100);
        check_eq("lb_we",   {31'd0, dmem_we},   32'd0);
        for (int i = 0; i < 3; i++) begin
            dmem_ack = (i == 2);
            #1;
            check_eq("lb_stall", {31'd0, stall_req}, 32'd1);
            check_eq("lb_req",   {31'd0, dmem_req},  32'd1);
            check_eq("lb_wben",  {31'd0, wb_en},     32'd0);
            tick();
        end
        dmem_ack   = 1'b0;
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        check_eq("lb_done_stall", {31'd0, stall_req}, 32'd0);
        check_eq("lb_done_req",   {31'd0, dmem_req},  32'd0);
        check_eq("lb_data",       wb_data,            32'hFFFF_FF80);
        check_eq("lb_wben_done",  {31'd0, wb_en},     32'd1);
        check_eq("lb_rd",         {27'd0, wb_reg_addr}, 32'd7);
        tick();

        // sh 0x102, ack in the issue cycle.
        set_op(32'h102, 3'd0, 2'd2, 1'b0, 32'hABCD_5678);
        dmem_ack = 1'b1;
        #1;
        check_eq("sh_be",    {28'd0, dmem_be},   32'hC);
        check_eq("sh_wdata", dmem_wdata,         32'h5678_5678);
        check_eq("sh_we",    {31'd0, dmem_we},   32'd1);
        check_eq("sh_stall", {31'd0, stall_req}, 32'd1);
        tick();
        dmem_ack = 1'b0;
        #1;
        check_eq("sh_done_stall", {31'd0, stall_req}, 32'd0);
        check_eq("sh_done_wben",  {31'd0, wb_en},     32'd0);
        tick();

        // sb 0x101: single lane, replicated byte.
        set_op(32'h101, 3'd0, 2'd1, 1'b0, 32'h1234_56A5);
        dmem_ack = 1'b1;
        #1;
        check_eq("sb_be",    {28'd0, dmem_be}, 32'h2);
        check_eq("sb_wdata", dmem_wdata,       32'hA5A5_A5A5);
        tick();
        dmem_ack = 1'b0;
        tick();

        // lhu 0x200 immediate ack, then a non-memory op: exactly one request.
        set_op(32'h200, 3'd5, 2'd0, 1'b1, 32'd0);
        dmem_rdata = 32'h0000_F00F;
        dmem_ack   = 1'b1;
        n_req      = 0;
        #1;
        n_req += int'(dmem_req);
        tick();
        dmem_ack = 1'b0;
        #1;
        n_req += int'(dmem_req);
        check_eq("lhu_data", wb_data,        32'h0000_F00F);
        check_eq("lhu_wben", {31'd0, wb_en}, 32'd1);
        tick();
        set_op(32'h55, 3'd0, 2'd0, 1'b0, 32'd0);
        #1;
        n_req += int'(dmem_req);
        check_eq("lhu_nreq",   n_req,   32'd1);
        check_eq("after_data", wb_data, 32'h55);
        tick();

        // lh 0x102 sign-extends the upper half.
        set_op(32'h102, 3'd2, 2'd0, 1'b1, 32'd0);
        dmem_rdata = 32'h8001_0000;
        dmem_ack   = 1'b1;
        tick();
        dmem_ack = 1'b0;
        #1;
        check_eq("lh_data", wb_data, 32'hFFFF_8001);
        tick();

        // Reset while waiting, late ack ignored.
        set_op(32'h300, 3'd3, 2'd0, 1'b1, 32'd0);
        tick();
        #1;
        check_eq("rw_wait_req", {31'd0, dmem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rw_rst_req",   {31'd0, dmem_req},  32'd0);
        check_eq("rw_rst_stall", {31'd0, stall_req}, 32'd0);
        tick();
        rst      = 1'b0;
        dmem_ack = 1'b1;
        set_op(32'h77, 3'd0, 2'd0, 1'b0, 32'd0);
        #1;
        check_eq("rw_late_req",   {31'd0, dmem_req},  32'd0);
        check_eq("rw_late_stall", {31'd0, stall_req}, 32'd0);
        check_eq("rw_late_data",  wb_data,            32'h77);
        tick();
        dmem_ack = 1'b0;

        // lw at a misaligned address.
        set_op(32'h102, 3'd3, 2'd0, 1'b1, 32'd0);
        #1;
`ifdef MEM_MISALIGN_TRAP_EN
        check_eq("mis_exc",   {31'd0, misalign_exc}, 32'd1);
        check_eq("mis_req",   {31'd0, dmem_req},     32'd0);
        check_eq("mis_wben",  {31'd0, wb_en},        32'd0);
        check_eq("mis_stall", {31'd0, stall_req},    32'd0);
        tick();
`else
        check_eq("mis_exc",  {31'd0, misalign_exc}, 32'd0);
        check_eq("mis_addr", dmem_addr,             32'h100);
        check_eq("mis_be",   {28'd0, dmem_be},      32'hF);
        check_eq("mis_req",  {31'd0, dmem_req},     32'd1);
        dmem_rdata = 32'hCAFE_F00D;
        dmem_ack   = 1'b1;
        tick();
        dmem_ack = 1'b0;
        #1;
        check_eq("mis_data", wb_data, 32'hCAFE_F00D);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RISC-V pipeline, sitting between the EX/MEM pipeline register and the MEM/WB register. It takes the registered ALU result, load/store type and store data, runs a single-outstanding request/acknowledge transaction on the data-memory port for loads and stores, aligns and sign/zero-extends load data, and presents write-back data to MEM/WB. While a transaction is pending it raises a stall request so the pipeline control holds EX/MEM and upstream stages.

## Interface
Parameters: none. Widths fixed: data 32, register address 5, loadtype 3, storetype 2.
- clk  in  1  clock; rst is synchronous, active-high; all state updates on posedge clk
- rst  in  1  synchronous active-high reset
- mem_alu_result  in  32  effective address (memory ops) or result (others)
- mem_wr_bck_en  in  1  write-back enable from EX/MEM
- mem_wr_reg_addr  in  5  destination register
- mem_loadtype  in  3  0 none, 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu; 6/7 treated as none
- mem_storetype  in  2  0 none, 1 sb, 2 sh, 3 sw
- mem_store_data  in  32  rs2 value for stores
- mem_isload  in  1  instruction is a load
- dmem_req  out  1  request valid
- dmem_we  out  1  1 store, 0 load
- dmem_addr  out  32  word address ({addr[31:2],2'b00})
- dmem_be  out  4  byte-lane enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  request completed; load data valid same cycle
- dmem_rdata  in  32  load data word
- wb_data  out  32  write-back value to MEM/WB
- wb_en  out  1  write-back enable to MEM/WB
- wb_reg_addr  out  5  destination to MEM/WB
- stall_req  out  1  hold EX/MEM and upstream this cycle
- misalign_exc  out  1  misaligned access flag (tied 0 without macro)

## Operation
- Memory op: load = mem_isload & loadtype in 1..5; store = storetype != 0 & not load. Both set: load wins, store ignored.
- FSM states IDLE, WAIT, DONE. Reset -> IDLE, rdata_q = 0.
- IDLE, no memory op: wb_data = mem_alu_result, wb_en/wb_reg_addr pass through, stall_req = 0, dmem_req = 0.
- IDLE, memory op: dmem_req = 1, stall_req = 1 combinationally. dmem_ack same cycle -> capture rdata into rdata_q, go DONE; else go WAIT.
- WAIT: dmem_req = 1, stall_req = 1, address/lanes from held EX/MEM inputs; on dmem_ack capture, go DONE.
- DONE: dmem_req = 0, stall_req = 0; load: wb_data = extracted rdata_q, wb_en = mem_wr_bck_en; store: wb_en = 0. Always -> IDLE (no re-issue while EX/MEM advances).
- wb_en = 0 whenever stall_req = 1.
- Store lanes: sb be = 1<<addr[1:0], wdata = {4{byte}}; sh be = addr[1] ? 1100 : 0011, wdata = {2{half}}; sw be = 1111.
- Load extract: byte lane addr[1:0], half lane addr[1]; lb/lh sign-extend, lbu/lhu zero-extend, lw whole word.
- dmem_ack in IDLE/DONE ignored.

## Timing
- Non-memory ops: zero added latency, combinational pass-through.
- Memory op: minimum 1 stall cycle (ack in issue cycle), result presented in DONE; each extra wait cycle adds one stall.
- rst high: dmem_req, stall_req, wb_en, misalign_exc = 0 that cycle; state IDLE next edge. Reset mid-WAIT abandons request; late ack ignored.
- dmem_addr/be/we/wdata stable throughout request (inputs held by stall).

## Configuration
- MEM_MISALIGN_TRAP_EN defined: lh/lhu/sh with addr[0]=1 or lw/sw with addr[1:0]!=0 issue no request, stall_req = 0, wb_en = 0, misalign_exc = 1 for that cycle; FSM stays IDLE.
- Undefined: misalignment ignored; lanes from addr bits as above (lw/sw ignore addr[1:0]); misalign_exc tied 0.

## Test plan
- add result 0x1234, wr_bck_en=1, rd=5 -> wb_data 0x1234, wb_en=1, stall_req=0, dmem_req=0 same cycle.
- lb addr 0x103, rdata 0x80FF_0000, ack after 2 wait cycles -> stall_req 3 cycles, DONE wb_data 0xFFFF_FF80.
- sh addr 0x102 data 0xABCD_5678, ack same cycle -> be 1100, wdata 0x5678_5678, we=1, one stall cycle, wb_en=0.
- lhu addr 0x200 rdata 0x0000_F00F ack immediate, next op non-memory -> wb_data 0x0000_F00F, single request (no re-issue in DONE).
- rst asserted in WAIT, ack next cycle -> dmem_req=0 immediately, ack ignored, state IDLE.
- Macro on: lw addr 0x102 -> misalign_exc=1, dmem_req=0, wb_en=0; macro off -> dmem_addr 0x100, be 1111.
